// File: rtl/hayes_cplx_pkg.sv
// Shared complex fixed-point definitions for the rational-function evaluator.
// Holds default widths, the unit constant, FSM states and the saturation helper.
package hayes_cplx_pkg;

  localparam int W_DEF    = 16;
  localparam int FRAC_DEF = 8;
  localparam int ONE_Q    = 1 << FRAC_DEF;

  typedef enum logic [1:0] {IDLE, NUM, DEN, DONE} state_t;

  typedef struct packed {
    logic signed [W_DEF-1:0] re;
    logic signed [W_DEF-1:0] im;
  } cplx_t;

  // Clamp a wide signed value into a w-bit two's complement range; flag clamping.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] x,
                                               input int w,
                                               output logic ovf);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    ovf = 1'b0;
    if (x > hi) begin
      ovf = 1'b1;
      return hi;
    end
    if (x < lo) begin
      ovf = 1'b1;
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/cplx_mult_sat.sv
// Combinational complex multiply in Q fixed point: full-precision products,
// floor shift by FRAC, then saturation of each component back to W bits.
module cplx_mult_sat
  import hayes_cplx_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic signed [W-1:0] a_re,
  input  logic signed [W-1:0] a_im,
  input  logic signed [W-1:0] b_re,
  input  logic signed [W-1:0] b_im,
  output logic signed [W-1:0] p_re,
  output logic signed [W-1:0] p_im,
  output logic                ovf
);

  logic signed [2*W:0] ar, ai, br, bi;
  logic signed [2*W:0] re_full, im_full;
  logic                ovf_re, ovf_im;

  // Products fit in 2W bits; the sum/difference needs one more.
  always_comb begin
    ar      = (2*W+1)'(a_re);
    ai      = (2*W+1)'(a_im);
    br      = (2*W+1)'(b_re);
    bi      = (2*W+1)'(b_im);
    re_full = ar * br - ai * bi;
    im_full = ar * bi + ai * br;
    ovf_re  = 1'b0;
    ovf_im  = 1'b0;
    p_re    = W'(sat_w(64'(re_full) >>> FRAC, W, ovf_re));
    p_im    = W'(sat_w(64'(im_full) >>> FRAC, W, ovf_im));
    ovf     = ovf_re | ovf_im;
  end

endmodule

// File: rtl/rational_eval_seq.sv
// Sequential evaluator of num = prod(z - zero_k) and den = prod(z - pole_k),
// one factor per cycle through a single shared saturating complex multiplier.
module rational_eval_seq
  import hayes_cplx_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int FRAC    = FRAC_DEF,
  parameter int N_ZEROS = 4,
  parameter int N_POLES = 4,
  localparam int N_MAX  = (N_ZEROS > N_POLES) ? N_ZEROS : N_POLES,
  localparam int IDX_W  = (N_MAX > 1) ? $clog2(N_MAX) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic                 cfg_sel,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic signed [W-1:0]  cfg_re,
  input  logic signed [W-1:0]  cfg_im,
  output logic                 cfg_nack,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [W-1:0]  z_re,
  input  logic signed [W-1:0]  z_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [W-1:0]  num_re,
  output logic signed [W-1:0]  num_im,
  output logic signed [W-1:0]  den_re,
  output logic signed [W-1:0]  den_im,
  output logic                 ovf
);

  localparam logic signed [W-1:0] ONE = W'(64'sd1 <<< FRAC);

  state_t state, next_state;

  logic signed [W-1:0] tab_re [2][N_MAX];
  logic signed [W-1:0] tab_im [2][N_MAX];

  logic signed [W-1:0] zr_q, zi_q;
  logic signed [W-1:0] acc_re, acc_im;
  logic [IDX_W-1:0]    k;
  logic                ovf_acc;

  logic                tsel;
  logic signed [W-1:0] diff_re, diff_im;
  logic                sub_ovf_re, sub_ovf_im;
  logic signed [W-1:0] prod_re, prod_im;
  logic                mul_ovf;
  logic                step_ovf;
  logic                last_zero, last_pole;
  logic                idx_ok, cfg_ok;

  always_comb begin
    idx_ok = cfg_sel ? (int'(cfg_idx) < N_POLES) : (int'(cfg_idx) < N_ZEROS);
    cfg_ok = cfg_we && (state == IDLE) && idx_ok;
  end

  // The table is flops, not RAM, so reset can clear every entry at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < N_MAX; i++) begin
          tab_re[s][i] <= '0;
          tab_im[s][i] <= '0;
        end
      end
      cfg_nack <= 1'b0;
    end else begin
      if (cfg_ok) begin
        tab_re[cfg_sel][cfg_idx] <= cfg_re;
        tab_im[cfg_sel][cfg_idx] <= cfg_im;
      end
      cfg_nack <= cfg_we && !cfg_ok;
    end
  end

  always_comb begin
    tsel       = (state == DEN);
    sub_ovf_re = 1'b0;
    sub_ovf_im = 1'b0;
    diff_re    = W'(sat_w(64'(zr_q) - 64'(tab_re[tsel][k]), W, sub_ovf_re));
    diff_im    = W'(sat_w(64'(zi_q) - 64'(tab_im[tsel][k]), W, sub_ovf_im));
    step_ovf   = sub_ovf_re | sub_ovf_im | mul_ovf;
    last_zero  = (k == IDX_W'(N_ZEROS - 1));
    last_pole  = (k == IDX_W'(N_POLES - 1));
  end

  cplx_mult_sat #(
    .W    (W),
    .FRAC (FRAC)
  ) u_mult (
    .a_re (acc_re),
    .a_im (acc_im),
    .b_re (diff_re),
    .b_im (diff_im),
    .p_re (prod_re),
    .p_im (prod_im),
    .ovf  (mul_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (in_valid)  next_state = NUM;
      NUM:  if (last_zero) next_state = DEN;
      DEN:  if (last_pole) next_state = DONE;
      DONE: if (out_ready) next_state = IDLE;
      default:             next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Results are only written at the end of each loop, so they hold through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zr_q    <= '0;
      zi_q    <= '0;
      acc_re  <= '0;
      acc_im  <= '0;
      k       <= '0;
      ovf_acc <= 1'b0;
      num_re  <= '0;
      num_im  <= '0;
      den_re  <= '0;
      den_im  <= '0;
      ovf     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            zr_q    <= z_re;
            zi_q    <= z_im;
            acc_re  <= ONE;
            acc_im  <= '0;
            ovf_acc <= 1'b0;
            k       <= '0;
          end
        end
        NUM: begin
          ovf_acc <= ovf_acc | step_ovf;
          if (last_zero) begin
            num_re <= prod_re;
            num_im <= prod_im;
            acc_re <= ONE;
            acc_im <= '0;
            k      <= '0;
          end else begin
            acc_re <= prod_re;
            acc_im <= prod_im;
            k      <= k + IDX_W'(1);
          end
        end
        DEN: begin
          ovf_acc <= ovf_acc | step_ovf;
          if (last_pole) begin
            den_re <= prod_re;
            den_im <= prod_im;
            ovf    <= ovf_acc | step_ovf;
            k      <= '0;
          end else begin
            acc_re <= prod_re;
            acc_im <= prod_im;
            k      <= k + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rational_eval_seq.sv
// Randomised self-checking bench for rational_eval_seq against a plain-integer
// model of the zero/pole products.
module tb_rational_eval_seq;
  import hayes_cplx_pkg::*;

  localparam int W  = 16;
  localparam int NZ = 2;
  localparam int NP = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cfg_we = 1'b0;
  logic               cfg_sel = 1'b0;
  logic [0:0]         cfg_idx = '0;
  logic signed [15:0] cfg_re = '0;
  logic signed [15:0] cfg_im = '0;
  logic               cfg_nack;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] z_re = '0;
  logic signed [15:0] z_im = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [15:0] num_re, num_im, den_re, den_im;
  logic               ovf;

  int tests = 0;
  int failures = 0;

  cplx_t model_tab [2][2];

  logic signed [15:0] res_nr, res_ni, res_dr, res_di;
  logic               res_ov;

  rational_eval_seq #(
    .W       (W),
    .FRAC    (8),
    .N_ZEROS (NZ),
    .N_POLES (NP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_idx   (cfg_idx),
    .cfg_re    (cfg_re),
    .cfg_im    (cfg_im),
    .cfg_nack  (cfg_nack),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .z_re      (z_re),
    .z_im      (z_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .num_re    (num_re),
    .num_im    (num_im),
    .den_re    (den_re),
    .den_im    (den_im),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint clampW(input longint x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  // Reference: multiply the factors out in exact integers, floor-scale, clamp.
  function automatic void modelEval(input longint zr, input longint zi,
                                    output longint nr, output longint ni,
                                    output longint dr, output longint di,
                                    output bit ov);
    longint ar, ai, br, bi, pr, pi;
    int nf;
    ov = 0;
    nr = 0; ni = 0; dr = 0; di = 0;
    for (int s = 0; s < 2; s++) begin
      ar = 256;
      ai = 0;
      nf = (s == 0) ? NZ : NP;
      for (int i = 0; i < nf; i++) begin
        br = zr - longint'(model_tab[s][i].re);
        bi = zi - longint'(model_tab[s][i].im);
        if (clampW(br) != br || clampW(bi) != bi) ov = 1;
        br = clampW(br);
        bi = clampW(bi);
        pr = (ar * br - ai * bi) >>> 8;
        pi = (ar * bi + ai * br) >>> 8;
        if (clampW(pr) != pr || clampW(pi) != pi) ov = 1;
        ar = clampW(pr);
        ai = clampW(pi);
      end
      if (s == 0) begin nr = ar; ni = ai; end
      else        begin dr = ar; di = ai; end
    end
  endfunction

  task automatic writeEntry(input int sel, input int idx, input int re, input int im);
    @(negedge clk);
    cfg_we  = 1'b1;
    cfg_sel = 1'(sel);
    cfg_idx = 1'(idx);
    cfg_re  = 16'(re);
    cfg_im  = 16'(im);
    @(negedge clk);
    cfg_we = 1'b0;
    checkOutput("wr_nack_idle", cfg_nack, 0);
    model_tab[sel][idx] = '{re: 16'(re), im: 16'(im)};
  endtask

  // One full evaluation, optionally with a held DONE, a write while busy, or a
  // write landing on the same edge as the accept.
  task automatic applyStimulus(input int zr, input int zi, input int hold,
                               input bit busy_wr, input bit accept_wr,
                               input int wr_re, input int wr_im, input string tag);
    int cyc;
    int unstable;
    longint enr, eni, edr, edi;
    bit eov;
    @(negedge clk);
    checkOutput({tag, "_in_ready_pre"}, in_ready, 1);
    z_re = 16'(zr);
    z_im = 16'(zi);
    in_valid = 1'b1;
    if (accept_wr) begin
      cfg_we = 1'b1; cfg_sel = 1'b0; cfg_idx = 1'b1;
      cfg_re = 16'(wr_re); cfg_im = 16'(wr_im);
      model_tab[0][1] = '{re: 16'(wr_re), im: 16'(wr_im)};
    end
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we = 1'b0;
    if (accept_wr) checkOutput({tag, "_nack_accept"}, cfg_nack, 0);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      if (busy_wr && cyc == 1) begin
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_idx = 1'b0;
        cfg_re = 16'sd1234; cfg_im = -16'sd77;
      end
      @(negedge clk);
      cyc++;
      if (busy_wr && cyc == 2) begin
        checkOutput({tag, "_nack_busy"}, cfg_nack, 1);
        cfg_we = 1'b0;
      end
    end
    checkOutput({tag, "_latency"}, cyc, 1 + NZ + NP);
    res_nr = num_re; res_ni = num_im; res_dr = den_re; res_di = den_im; res_ov = ovf;
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (num_re !== res_nr || num_im !== res_ni || den_re !== res_dr ||
          den_im !== res_di || ovf !== res_ov || in_ready !== 1'b0 || out_valid !== 1'b1)
        unstable++;
    end
    if (hold > 0) checkOutput({tag, "_hold_stable"}, unstable, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_in_ready_after"}, in_ready, 1);
    modelEval(longint'(16'(zr)), longint'(16'(zi)), enr, eni, edr, edi, eov);
    checkOutput({tag, "_num_re"}, res_nr, enr);
    checkOutput({tag, "_num_im"}, res_ni, eni);
    checkOutput({tag, "_den_re"}, res_dr, edr);
    checkOutput({tag, "_den_im"}, res_di, edi);
    checkOutput({tag, "_ovf"}, res_ov, eov);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bad;
    int span;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 2; i++)
        model_tab[s][i] = '{re: 16'sd0, im: 16'sd0};

    #12;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_num_re", num_re, 0);
    checkOutput("rst_num_im", num_im, 0);
    checkOutput("rst_den_re", den_re, 0);
    checkOutput("rst_den_im", den_im, 0);
    checkOutput("rst_ovf", ovf, 0);
    checkOutput("rst_cfg_nack", cfg_nack, 0);
    @(negedge clk);
    rst_n = 1'b1;

    writeEntry(0, 0, 2560, 2560);
    applyStimulus(256, 0, 0, 0, 0, 0, 0, "basic");
    checkOutput("basic_num_re_k", res_nr, -2304);
    checkOutput("basic_num_im_k", res_ni, -2560);
    checkOutput("basic_den_re_k", res_dr, 256);
    checkOutput("basic_den_im_k", res_di, 0);
    checkOutput("basic_ovf_k", res_ov, 0);

    writeEntry(0, 0, 0, 0);
    applyStimulus(0, 256, 0, 0, 0, 0, 0, "imag");
    checkOutput("imag_num_re_k", res_nr, -256);
    checkOutput("imag_num_im_k", res_ni, 0);
    checkOutput("imag_den_re_k", res_dr, -256);
    checkOutput("imag_den_im_k", res_di, 0);

    applyStimulus(25600, 0, 0, 0, 0, 0, 0, "sat");
    checkOutput("sat_num_re_k", res_nr, 32767);
    checkOutput("sat_num_im_k", res_ni, 0);
    checkOutput("sat_den_re_k", res_dr, 32767);
    checkOutput("sat_ovf_k", res_ov, 1);

    writeEntry(1, 1, 128, -64);
    applyStimulus(300, 200, 5, 0, 0, 0, 0, "backpressure");
    applyStimulus(384, 128, 0, 1, 0, 0, 0, "busy_write");
    applyStimulus(300, -100, 0, 0, 1, 700, -300, "accept_write");

    for (int r = 0; r < 24; r++) begin
      span = (r % 4 == 3) ? 32767 : 1023;
      for (int s = 0; s < 2; s++)
        for (int i = 0; i < 2; i++)
          writeEntry(s, i, int'($urandom_range(2 * span)) - span,
                     int'($urandom_range(2 * span)) - span);
      applyStimulus(int'($urandom_range(2 * span)) - span,
                    int'($urandom_range(2 * span)) - span,
                    int'($urandom_range(2)), 0, 0, 0, 0, "random");
    end

    @(negedge clk);
    z_re = 16'sd256; z_im = 16'sd0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    checkOutput("midrst_in_ready", in_ready, 1);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_num_re", num_re, 0);
    checkOutput("midrst_den_re", den_re, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 2; i++)
        model_tab[s][i] = '{re: 16'sd0, im: 16'sd0};
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    checkOutput("midrst_quiet", bad, 0);
    applyStimulus(256, 256, 0, 0, 0, 0, 0, "post_reset");
    checkOutput("post_reset_num_re_k", res_nr, 0);
    checkOutput("post_reset_num_im_k", res_ni, 512);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
